pipeline_sequencer: RTL

- Sequences the 5-stage pipeline around the main decoder.
- Generates the decoder's enable input (o_control_mux: 1 = normal decode, 0 = bubble) together with PC, IF/ID and pipeline-register enable/flush strobes.
- Detects load-use hazards, applies branch-taken flushes, and runs a run/step/halt FSM driven by the debug unit.
- Sits between the debug unit, the ID/EX hazard sources, and the decoder/pipeline registers.

---
 rtl/pipeline_sequencer_pkg.sv | 22 ++
 rtl/pipeline_sequencer_hazard_detect.sv | 18 +
 rtl/pipeline_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pipeline_sequencer_pkg.sv
// Shared constants for the pipeline sequencer: FSM encodings, parameter defaults and
// the active-state helper used by the top level.
package pipeline_sequencer_pkg;

  localparam int unsigned RegAddrBitsDefault = 5;
  localparam int unsigned DrainCyclesDefault = 4;
  localparam int unsigned CountBitsDefault   = 32;

  localparam int unsigned StateBits = 3;

  localparam logic [StateBits-1:0] StIdle  = 3'd0;
  localparam logic [StateBits-1:0] StRun   = 3'd1;
  localparam logic [StateBits-1:0] StStep  = 3'd2;
  localparam logic [StateBits-1:0] StDrain = 3'd3;
  localparam logic [StateBits-1:0] StDone  = 3'd4;

  // Pipeline registers latch only in these states.
  function automatic logic is_active(input logic [StateBits-1:0] state);
    return (state == StRun) || (state == StStep) || (state == StDrain);
  endfunction

endpackage

// File: rtl/pipeline_sequencer_hazard_detect.sv
// Load-use comparator: a load in ID/EX whose destination feeds either ID source.
module pipeline_sequencer_hazard_detect
  import pipeline_sequencer_pkg::*;
#(
  parameter int unsigned RegAddrBits = RegAddrBitsDefault
) (
  input  logic                   idex_memread_i,
  input  logic [RegAddrBits-1:0] idex_rt_i,
  input  logic [RegAddrBits-1:0] ifid_rs_i,
  input  logic [RegAddrBits-1:0] ifid_rt_i,
  output logic                   stall_o
);

  // Register zero is hard-wired, so a load into it never creates a dependency.
  assign stall_o = idex_memread_i && (idex_rt_i != '0) &&
                   ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

endmodule

// File: rtl/pipeline_sequencer.sv
// Run/step/halt sequencer for the 5-stage pipeline: produces decoder enable, PC/IF-ID
// write enables and flush strobes, plus active-cycle and load-use stall counters.
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int unsigned REG_ADDR_BITS = RegAddrBitsDefault,
  parameter int unsigned DRAIN_CYCLES  = DrainCyclesDefault,
  parameter int unsigned COUNT_BITS    = CountBitsDefault
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_run,
  input  logic                     i_step,
  input  logic                     i_pause,
  input  logic                     i_halt_instr,
  input  logic                     i_branch_taken,
  input  logic                     i_idex_memread,
  input  logic [REG_ADDR_BITS-1:0] i_idex_rt,
  input  logic [REG_ADDR_BITS-1:0] i_ifid_rs,
  input  logic [REG_ADDR_BITS-1:0] i_ifid_rt,
  output logic                     o_pipe_enable,
  output logic                     o_pc_write,
  output logic                     o_ifid_write,
  output logic                     o_control_mux,
  output logic                     o_ifid_flush,
  output logic                     o_idex_flush,
  output logic                     o_exmem_flush,
  output logic                     o_halted,
  output logic [COUNT_BITS-1:0]    o_cycle_count,
  output logic [COUNT_BITS-1:0]    o_stall_count
);

  localparam int unsigned DrainBits = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DrainBits-1:0] DrainInit = DrainBits'(DRAIN_CYCLES - 1);

  logic [StateBits-1:0]  state_q, state_d;
  logic                  step_mode_q, step_mode_d;
  logic [DrainBits-1:0]  drain_q, drain_d;
  logic [COUNT_BITS-1:0] cycle_q, stall_q;
  logic                  load_use;
  logic                  stall_event;
  logic [StateBits-1:0]  resume_state;

  pipeline_sequencer_hazard_detect #(
    .RegAddrBits (REG_ADDR_BITS)
  ) u_hazard_detect (
    .idex_memread_i (i_idex_memread),
    .idex_rt_i      (i_idex_rt),
    .ifid_rs_i      (i_ifid_rs),
    .ifid_rt_i      (i_ifid_rt),
    .stall_o        (load_use)
  );

  // Where an ordinary RUN/STEP cycle goes next.
  always_comb begin
    resume_state = StRun;
    if (state_q == StStep || i_pause) begin
      resume_state = StIdle;
    end
  end

  always_comb begin
    state_d       = state_q;
    step_mode_d   = step_mode_q;
    drain_d       = drain_q;
    stall_event   = 1'b0;
    o_pipe_enable = 1'b0;
    o_pc_write    = 1'b0;
    o_ifid_write  = 1'b0;
    o_control_mux = 1'b0;
    o_ifid_flush  = 1'b0;
    o_idex_flush  = 1'b0;
    o_exmem_flush = 1'b0;
    o_halted      = 1'b0;

    case (state_q)
      StIdle: begin
        if (i_run) begin
          state_d     = StRun;
          step_mode_d = 1'b0;
        end else if (i_step) begin
          state_d     = StStep;
          step_mode_d = 1'b1;
        end
      end

      StRun, StStep: begin
        o_pipe_enable = 1'b1;
        o_pc_write    = 1'b1;
        o_ifid_write  = 1'b1;
        o_control_mux = 1'b1;
        if (i_branch_taken) begin
          o_ifid_flush  = 1'b1;
          o_idex_flush  = 1'b1;
          o_exmem_flush = 1'b1;
          state_d       = resume_state;
        end else if (i_halt_instr) begin
          // HALT itself keeps flowing down the pipe; nothing younger follows it.
          o_pc_write   = 1'b0;
          o_ifid_flush = 1'b1;
          state_d      = StDrain;
          drain_d      = DrainInit;
        end else if (load_use) begin
          o_pc_write    = 1'b0;
          o_ifid_write  = 1'b0;
          o_control_mux = 1'b0;
          stall_event   = 1'b1;
          state_d       = resume_state;
        end else begin
          state_d = resume_state;
        end
      end

      StDrain: begin
        o_pipe_enable = 1'b1;
        o_ifid_write  = 1'b1;
        if (i_branch_taken) begin
          // The HALT was speculative; resume in whatever mode we came from.
          o_pc_write    = 1'b1;
          o_control_mux = 1'b1;
          o_ifid_flush  = 1'b1;
          o_idex_flush  = 1'b1;
          o_exmem_flush = 1'b1;
          state_d       = step_mode_q ? StIdle : StRun;
        end else begin
          o_ifid_flush = 1'b1;
          if (drain_q == '0) begin
            state_d = StDone;
          end else begin
            drain_d = drain_q - 1'b1;
          end
        end
      end

      StDone: begin
        o_halted = 1'b1;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= StIdle;
      step_mode_q <= 1'b0;
      drain_q     <= '0;
    end else begin
      state_q     <= state_d;
      step_mode_q <= step_mode_d;
      drain_q     <= drain_d;
    end
  end

  // Counters wrap naturally at 2^COUNT_BITS.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cycle_q <= '0;
      stall_q <= '0;
    end else begin
      if (is_active(state_q)) begin
        cycle_q <= cycle_q + COUNT_BITS'(1);
      end
      if (stall_event) begin
        stall_q <= stall_q + COUNT_BITS'(1);
      end
    end
  end

  assign o_cycle_count = cycle_q;
  assign o_stall_count = stall_q;

endmodule
